// File: rtl/hop_pkg.sv
// rtl/hop_pkg.sv - shared direction/state types for the hop input and hop stages
package hop_pkg;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    DOWN  = 2'd1,
    LEFT  = 2'd2,
    RIGHT = 2'd3
  } dir_t;

  typedef enum logic {
    IDLE     = 1'b0,
    COOLDOWN = 1'b1
  } hop_state_t;

  // rise[0]=up .. rise[3]=right; lower index wins on simultaneous presses
  function automatic dir_t press_priority(input logic [3:0] rise);
    if (rise[0])      return UP;
    else if (rise[1]) return DOWN;
    else if (rise[2]) return LEFT;
    else              return RIGHT;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - 2-flop synchroniser, counting debouncer and press (0->1) pulse
module btn_debounce #(
  parameter int DB_CYCLES = 250000,
  parameter int DB_W      = 18
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic rise
);

  localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DB_CYCLES - 1);

  logic            sync1;
  logic            sync2;
  logic            stable;
  logic            stable_q;
  logic [DB_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      stable   <= 1'b0;
      stable_q <= 1'b0;
      cnt      <= '0;
    end else begin
      sync1    <= btn;
      sync2    <= sync1;
      stable_q <= stable;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= ~stable;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign rise = stable & ~stable_q;

endmodule

// File: rtl/hop_input_ctrl.sv
// rtl/hop_input_ctrl.sv - debounced buttons to strobe-aligned, cooldown-spaced hop requests
module hop_input_ctrl #(
  parameter int DB_CYCLES   = 250000,
  parameter int DB_W        = 18,
  parameter int HOLD_FRAMES = 12,
  parameter int HF_W        = 8
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_ani_stb,
  input  logic i_enable,
  input  logic i_btn_up,
  input  logic i_btn_down,
  input  logic i_btn_left,
  input  logic i_btn_right,
  output logic o_up,
  output logic o_down,
  output logic o_left,
  output logic o_right,
  output logic o_pending,
  output logic o_busy
);

  import hop_pkg::*;

  logic [3:0]      btn_raw;
  logic [3:0]      rise;
  logic            press_any;
  dir_t            press_dir;
  hop_state_t      state;
  hop_state_t      state_next;
  logic [HF_W-1:0] cool_cnt;
  logic            pend_valid;
  dir_t            pend_dir;
  logic            issue;
  logic            busy;
  logic [3:0]      pulse;

  assign btn_raw = {i_btn_right, i_btn_left, i_btn_down, i_btn_up};

  for (genvar g = 0; g < 4; g++) begin : g_db
    btn_debounce #(
      .DB_CYCLES(DB_CYCLES),
      .DB_W     (DB_W)
    ) u_db (
      .clk  (i_clk),
      .rst_n(i_rst_n),
      .btn  (btn_raw[g]),
      .rise (rise[g])
    );
  end

  assign press_any = |rise;
  assign press_dir = press_priority(rise);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (!i_enable) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:     if (issue && HOLD_FRAMES > 0) state_next = COOLDOWN;
        COOLDOWN: if (i_ani_stb && cool_cnt <= HF_W'(1)) state_next = IDLE;
        default:  state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    issue = (state == IDLE) && pend_valid && i_enable && i_ani_stb;
    busy  = (state == COOLDOWN);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cool_cnt <= '0;
    end else if (!i_enable) begin
      cool_cnt <= '0;
    end else if (issue) begin
      cool_cnt <= HF_W'(HOLD_FRAMES);
    end else if (state == COOLDOWN && i_ani_stb && cool_cnt != '0) begin
      cool_cnt <= cool_cnt - 1'b1;
    end
  end

  // A press landing on the issue cycle wins over the clear, so it is not lost
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pend_valid <= 1'b0;
      pend_dir   <= UP;
    end else if (!i_enable) begin
      pend_valid <= 1'b0;
    end else if (press_any) begin
      pend_valid <= 1'b1;
      pend_dir   <= press_dir;
    end else if (issue) begin
      pend_valid <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)   pulse <= '0;
    else if (issue) pulse <= 4'b0001 << pend_dir;
    else            pulse <= '0;
  end

  assign o_up      = pulse[0];
  assign o_down    = pulse[1];
  assign o_left    = pulse[2];
  assign o_right   = pulse[3];
  assign o_pending = pend_valid;
  assign o_busy    = busy;

endmodule

// File: tb/tb_hop_input_ctrl.sv
// tb/tb_hop_input_ctrl.sv - table-driven, directed and random checks of hop_input_ctrl
module tb_hop_input_ctrl;

  localparam int DB = 4;
  localparam int HF = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ani_stb = 1'b0;
  logic       enable = 1'b1;
  logic [3:0] btn = '0;
  logic       o_up, o_down, o_left, o_right, o_pending, o_busy;

  always #5 clk = ~clk;

  hop_input_ctrl #(
    .DB_CYCLES  (DB),
    .DB_W       (3),
    .HOLD_FRAMES(HF),
    .HF_W       (8)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_ani_stb  (ani_stb),
    .i_enable   (enable),
    .i_btn_up   (btn[0]),
    .i_btn_down (btn[1]),
    .i_btn_left (btn[2]),
    .i_btn_right(btn[3]),
    .o_up       (o_up),
    .o_down     (o_down),
    .o_left     (o_left),
    .o_right    (o_right),
    .o_pending  (o_pending),
    .o_busy     (o_busy)
  );

  int checks = 0;
  int errors = 0;
  int ph = 0;
  int pc[4];

  // Reference model: raw delay line, run-length debounce, strobe counting since last issue
  logic       m_s1[4], m_s2[4], m_stable[4], m_just[4];
  int         m_run[4];
  bit         m_pend;
  int         m_dir;
  bit         m_cd_active;
  int         m_cd_strobes;
  logic [3:0] m_pulse;

  function automatic bit m_busy();
    return m_cd_active && (m_cd_strobes < HF);
  endfunction

  function automatic logic [5:0] m_obs();
    return {m_busy(), m_pend, m_pulse};
  endfunction

  function automatic logic [5:0] dut_obs();
    return {o_busy, o_pending, o_right, o_left, o_down, o_up};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_s1[i] = 1'b0; m_s2[i] = 1'b0; m_stable[i] = 1'b0; m_just[i] = 1'b0; m_run[i] = 0;
    end
    m_pend = 1'b0; m_dir = 0; m_cd_active = 1'b0; m_cd_strobes = 0; m_pulse = '0;
  endtask

  task automatic model_step(input logic [3:0] b, input logic en, input logic stb);
    bit issue;
    bit any;
    int pdir;
    issue   = en && stb && m_pend && !m_busy();
    m_pulse = issue ? (4'b0001 << m_dir) : 4'b0000;
    any  = 1'b0;
    pdir = 0;
    for (int i = 3; i >= 0; i--) if (m_just[i]) begin any = 1'b1; pdir = i; end
    if (!en)        m_pend = 1'b0;
    else if (any)   begin m_pend = 1'b1; m_dir = pdir; end
    else if (issue) m_pend = 1'b0;
    if (!en)                  m_cd_active = 1'b0;
    else if (issue)           begin m_cd_active = (HF > 0); m_cd_strobes = 0; end
    else if (stb && m_busy()) m_cd_strobes++;
    for (int i = 0; i < 4; i++) begin
      m_just[i] = 1'b0;
      if (m_s2[i] != m_stable[i]) begin
        m_run[i]++;
        if (m_run[i] == DB) begin
          m_stable[i] = ~m_stable[i];
          m_run[i]    = 0;
          m_just[i]   = m_stable[i];
        end
      end else begin
        m_run[i] = 0;
      end
      m_s2[i] = m_s1[i];
      m_s1[i] = b[i];
    end
  endtask

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", name, got, exp);
    end
  endtask

  task automatic step(input logic [3:0] b, input logic en, input logic stb);
    logic [5:0] obs;
    btn = b; enable = en; ani_stb = stb;
    model_step(b, en, stb);
    @(posedge clk);
    @(negedge clk);
    ph++;
    obs = dut_obs();
    for (int i = 0; i < 4; i++) pc[i] += int'(obs[i]);
    checks++;
    if (obs !== m_obs()) begin
      errors++;
      $display("FAIL model_cmp ph %0d got %b exp %b", ph, obs, m_obs());
    end
  endtask

  task automatic run_n(input int n, input logic [3:0] b, input logic en);
    repeat (n) step(b, en, (ph % 10) == 9);
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 4; i++) pc[i] = 0;
  endtask

  // Bounded wait on a model condition: 0 = pending, 1 = busy
  task automatic wait_for(input string name, input int what, input logic [3:0] b, input int maxc);
    int k;
    k = 0;
    while (!(what == 1 ? m_busy() : m_pend) && k < maxc) begin
      run_n(1, b, 1'b1);
      k++;
    end
    check(name, int'(what == 1 ? m_busy() : m_pend), 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("reset_outputs", int'(dut_obs()), 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [3:0] b;
    logic       stb;
    int         reps;
    logic [5:0] exp;
  } vec_t;

  vec_t tbl[$];

  initial begin
    // {buttons, strobe, repeat, expected {busy,pending,right,left,down,up}}
    tbl.push_back('{4'b0001, 1'b0, 6, 6'b000000});
    tbl.push_back('{4'b0001, 1'b0, 3, 6'b010000});
    tbl.push_back('{4'b0001, 1'b1, 1, 6'b100001});
    tbl.push_back('{4'b0001, 1'b0, 9, 6'b100000});
    tbl.push_back('{4'b0001, 1'b1, 1, 6'b100000});
    tbl.push_back('{4'b0001, 1'b0, 9, 6'b100000});
    tbl.push_back('{4'b0001, 1'b1, 1, 6'b100000});
    tbl.push_back('{4'b0001, 1'b0, 9, 6'b100000});
    tbl.push_back('{4'b0001, 1'b1, 1, 6'b000000});
    tbl.push_back('{4'b0001, 1'b0, 5, 6'b000000});
    for (int i = 0; i < 5; i++) begin
      tbl.push_back('{4'b0101, 1'b0, 2, 6'b000000});
      tbl.push_back('{4'b0001, 1'b0, 2, 6'b000000});
    end
    tbl.push_back('{4'b0001, 1'b1, 10, 6'b000000});
    tbl.push_back('{4'b0000, 1'b1, 10, 6'b000000});

    clear_counts();
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_outputs", int'(dut_obs()), 0);
    rst_n = 1'b1;

    foreach (tbl[r]) begin
      for (int k = 0; k < tbl[r].reps; k++) begin
        step(tbl[r].b, 1'b1, tbl[r].stb);
        check($sformatf("table_r%0d_k%0d", r, k), int'(dut_obs()), int'(tbl[r].exp));
      end
    end

    // Press down then right during cooldown: only right issues, after cooldown ends
    run_n(40, 4'b0000, 1'b1);
    clear_counts();
    wait_for("cd_reach_busy", 1, 4'b0001, 60);
    run_n(8, 4'b0011, 1'b1);
    run_n(8, 4'b1011, 1'b1);
    check("cd_still_busy", int'(o_busy), 1);
    run_n(40, 4'b1011, 1'b1);
    check("cd_up_pulses", pc[0], 1);
    check("cd_down_pulses", pc[1], 0);
    check("cd_right_pulses", pc[3], 1);

    // Simultaneous up and right rise
    run_n(40, 4'b0000, 1'b1);
    clear_counts();
    run_n(40, 4'b1001, 1'b1);
    check("simul_up_pulses", pc[0], 1);
    check("simul_right_pulses", pc[3], 0);

    // Enable dropped while pending, then re-enabled with button held
    run_n(40, 4'b0000, 1'b1);
    clear_counts();
    wait_for("en_reach_pending", 0, 4'b0010, 20);
    step(4'b0010, 1'b0, 1'b0);
    check("en_pending_cleared", int'(o_pending), 0);
    run_n(5, 4'b0010, 1'b0);
    run_n(40, 4'b0010, 1'b1);
    check("en_down_pulses", pc[1], 0);

    // Reset mid-cooldown with button held
    run_n(20, 4'b0000, 1'b1);
    wait_for("rst_reach_busy", 1, 4'b0001, 60);
    run_n(5, 4'b0001, 1'b1);
    do_reset();
    clear_counts();
    run_n(40, 4'b0001, 1'b1);
    check("rst_up_pulses", pc[0], 1);

    // Random buttons (slowly changing or bouncing) and occasional enable toggles
    begin
      logic [3:0] rb;
      logic       ren;
      rb  = '0;
      ren = 1'b1;
      for (int c = 0; c < 4000; c++) begin
        if ($urandom_range(0, 15) == 0) rb[$urandom_range(0, 3)] ^= 1'b1;
        if ($urandom_range(0, 299) == 0) ren = ~ren;
        step(rb, ren, (ph % 10) == 9);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
